// File: rtl/clock_pkg.sv
// Shared types and widths for the alarm-clock controller.
//   mode_t : operating mode as seen on the Mode output (RUN/TSET/ASET)
//   buzz_t : buzzer state machine encoding (IDLE/RING/SNOOZE)
//   SEC_W/MIN_W/HRS_W : widths of the datapath time counters read back
package clock_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HRS_W = 5;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TSET = 2'b01,
    ASET = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10
  } buzz_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/buzz_fsm.sv
// Buzzer / snooze state machine for the alarm clock.
//   Clk, Reset : clock and synchronous active-high reset
//   Pulse      : one-second tick strobe, paces the ring and snooze timers
//   Trigger    : one-cycle alarm start request
//   Alarmon    : alarm enable; dropping it cancels ringing or snoozing
//   Snooze     : level-sampled snooze request while ringing
//   Buzz       : registered buzzer drive, high only in RING
module buzz_fsm
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Pulse,
  input  logic Trigger,
  input  logic Alarmon,
  input  logic Snooze,
  output logic Buzz
);

  localparam int CNT_W = $clog2(max_int(RING_SECS, SNOOZE_SECS)) + 1;
  localparam logic [CNT_W-1:0] RING_END = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNZ_END  = CNT_W'(SNOOZE_SECS);

  buzz_t            r_state;
  buzz_t            w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_buzz;

  // The timer terminates on the Pulse that completes the count, so the
  // state change lands on the same edge that samples that Pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + CNT_W'(1);
    case (r_state)
      IDLE: begin
        if (Trigger) begin
          w_state_nxt = RING;
          w_cnt_nxt   = '0;
        end
      end
      RING: begin
        // Disabling the alarm outranks a snooze request.
        if (!Alarmon) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (Snooze) begin
          w_state_nxt = SNOOZE;
          w_cnt_nxt   = '0;
        end else if (Pulse) begin
          if (w_cnt_inc == RING_END) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      SNOOZE: begin
        if (!Alarmon) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (Pulse) begin
          if (w_cnt_inc == SNZ_END) begin
            w_state_nxt = RING;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buzz  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buzz  <= (w_state_nxt == RING);
    end
  end

  assign Buzz = r_buzz;

endmodule

// File: rtl/clock_ctrl.sv
// Sequencing controller for the alarm-clock datapath.
//   Clk, Reset          : clock and synchronous active-high reset
//   Pulse               : one-second tick strobe
//   Timeset, Alarmset   : mode requests (Timeset wins)
//   Minadv, Hrsadv      : advance minutes / hours, one step per Pulse
//   Alarmon, Snooze     : alarm enable and snooze request
//   TSec/TMin/THrs      : current time read back from the datapath
//   AMin/AHrs           : alarm time read back from the datapath
//   SecInc/MinInc/HrsInc/SecClr : registered time-counter strobes
//   AMinInc/AHrsInc     : registered alarm-register strobes
//   DispSel             : 0 shows time, 1 shows alarm
//   Mode                : 00 RUN, 01 TSET, 10 ASET
//   Buzz                : buzzer drive
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 59,
  parameter int HRS_MAX     = 23,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Pulse,
  input  logic             Timeset,
  input  logic             Alarmset,
  input  logic             Minadv,
  input  logic             Hrsadv,
  input  logic             Alarmon,
  input  logic             Snooze,
  input  logic [SEC_W-1:0] TSec,
  input  logic [MIN_W-1:0] TMin,
  input  logic [HRS_W-1:0] THrs,
  input  logic [MIN_W-1:0] AMin,
  input  logic [HRS_W-1:0] AHrs,
  output logic             SecInc,
  output logic             MinInc,
  output logic             HrsInc,
  output logic             SecClr,
  output logic             AMinInc,
  output logic             AHrsInc,
  output logic             DispSel,
  output logic [1:0]       Mode,
  output logic             Buzz
);

  // Terminal counts must be representable on the read-back buses.
  if (SEC_MAX >= (1 << SEC_W) || MIN_MAX >= (1 << MIN_W) ||
      HRS_MAX >= (1 << HRS_W)) begin : g_bad_cfg
    $error("clock_ctrl: terminal count does not fit counter width");
  end

  mode_t r_mode;
  mode_t w_mode_nxt;
  logic  r_disp_sel;
  logic  r_sec_inc, r_min_inc, r_hrs_inc, r_sec_clr, r_amin_inc, r_ahrs_inc;
  logic  w_sec_inc, w_min_inc, w_hrs_inc, w_sec_clr, w_amin_inc, w_ahrs_inc;
  logic  w_sec_end, w_min_end;
  logic  w_match;
  logic  r_match, r_match_d;
  logic  w_trigger;

  assign w_sec_end = (TSec == SEC_W'(SEC_MAX));
  assign w_min_end = (TMin == MIN_W'(MIN_MAX));
  assign w_match   = (THrs == AHrs) && (TMin == AMin);

  // Strobes are qualified by the mode currently held in r_mode, so a Pulse
  // coinciding with a mode change still follows the old mode's rules.
  always_comb begin
    w_mode_nxt = Timeset ? TSET : (Alarmset ? ASET : RUN);
    w_sec_inc  = 1'b0;
    w_min_inc  = 1'b0;
    w_hrs_inc  = 1'b0;
    w_amin_inc = 1'b0;
    w_ahrs_inc = 1'b0;
    case (r_mode)
      TSET: begin
        // Manual setting: no seconds, no minute-to-hour carry.
        w_min_inc = Pulse & Minadv;
        w_hrs_inc = Pulse & Hrsadv;
      end
      ASET: begin
        w_sec_inc  = Pulse;
        w_min_inc  = Pulse & w_sec_end;
        w_hrs_inc  = Pulse & w_sec_end & w_min_end;
        w_amin_inc = Pulse & Minadv;
        w_ahrs_inc = Pulse & Hrsadv;
      end
      default: begin
        w_sec_inc = Pulse;
        w_min_inc = Pulse & w_sec_end;
        w_hrs_inc = Pulse & w_sec_end & w_min_end;
      end
    endcase
    w_sec_clr = (w_mode_nxt == TSET) && (r_mode != TSET);
  end

  // A match that rises while in TSET is absorbed into the history, so it
  // cannot fire once the user leaves time-set mode.
  assign w_trigger = r_match & ~r_match_d & Alarmon & (r_mode != TSET);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mode     <= RUN;
      r_disp_sel <= 1'b0;
      r_sec_inc  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hrs_inc  <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_amin_inc <= 1'b0;
      r_ahrs_inc <= 1'b0;
      r_match    <= 1'b0;
      r_match_d  <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_disp_sel <= (w_mode_nxt == ASET);
      r_sec_inc  <= w_sec_inc;
      r_min_inc  <= w_min_inc;
      r_hrs_inc  <= w_hrs_inc;
      r_sec_clr  <= w_sec_clr;
      r_amin_inc <= w_amin_inc;
      r_ahrs_inc <= w_ahrs_inc;
      r_match    <= w_match;
      r_match_d  <= r_match;
    end
  end

  buzz_fsm #(
    .RING_SECS   (RING_SECS),
    .SNOOZE_SECS (SNOOZE_SECS)
  ) u_buzz_fsm (
    .Clk     (Clk),
    .Reset   (Reset),
    .Pulse   (Pulse),
    .Trigger (w_trigger),
    .Alarmon (Alarmon),
    .Snooze  (Snooze),
    .Buzz    (Buzz)
  );

  assign SecInc  = r_sec_inc;
  assign MinInc  = r_min_inc;
  assign HrsInc  = r_hrs_inc;
  assign SecClr  = r_sec_clr;
  assign AMinInc = r_amin_inc;
  assign AHrsInc = r_ahrs_inc;
  assign DispSel = r_disp_sel;
  assign Mode    = r_mode;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with shortened ring/snooze timers.
module tb_clock_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Pulse, Timeset, Alarmset, Minadv, Hrsadv, Alarmon, Snooze;
  logic [5:0] TSec, TMin, AMin;
  logic [4:0] THrs, AHrs;
  logic       SecInc, MinInc, HrsInc, SecClr, AMinInc, AHrsInc, DispSel, Buzz;
  logic [1:0] Mode;

  int total = 0;
  int bad   = 0;
  int n_sec, n_min, n_hrs, n_clr, n_amin, n_ahrs;

  always #5 Clk = ~Clk;

  clock_ctrl #(
    .SEC_MAX     (59),
    .MIN_MAX     (59),
    .HRS_MAX     (23),
    .RING_SECS   (4),
    .SNOOZE_SECS (3)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Pulse    (Pulse),
    .Timeset  (Timeset),
    .Alarmset (Alarmset),
    .Minadv   (Minadv),
    .Hrsadv   (Hrsadv),
    .Alarmon  (Alarmon),
    .Snooze   (Snooze),
    .TSec     (TSec),
    .TMin     (TMin),
    .THrs     (THrs),
    .AMin     (AMin),
    .AHrs     (AHrs),
    .SecInc   (SecInc),
    .MinInc   (MinInc),
    .HrsInc   (HrsInc),
    .SecClr   (SecClr),
    .AMinInc  (AMinInc),
    .AHrsInc  (AHrsInc),
    .DispSel  (DispSel),
    .Mode     (Mode),
    .Buzz     (Buzz)
  );

  wire [9:0] all_out = {SecInc, MinInc, HrsInc, SecClr, AMinInc, AHrsInc,
                        DispSel, Mode, Buzz};

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_counts();
    n_sec = 0; n_min = 0; n_hrs = 0; n_clr = 0; n_amin = 0; n_ahrs = 0;
  endtask

  task automatic acc();
    n_sec  += int'(SecInc);
    n_min  += int'(MinInc);
    n_hrs  += int'(HrsInc);
    n_clr  += int'(SecClr);
    n_amin += int'(AMinInc);
    n_ahrs += int'(AHrsInc);
  endtask

  // One Pulse cycle followed by one quiet cycle, counting strobes on both.
  task automatic pulse_count();
    Pulse = 1'b1; tick(); acc();
    Pulse = 1'b0; tick(); acc();
  endtask

  task automatic pulse_gap();
    Pulse = 1'b1; tick();
    Pulse = 1'b0; tick();
  endtask

  // Drop the match for two cycles, then restore it to create a fresh edge.
  task automatic retrigger();
    TMin = 6'd2; tick(); tick();
    TMin = 6'd1; tick(); tick();
  endtask

  initial begin
    Reset = 1'b1; Pulse = 1'b1; Timeset = 1'b0; Alarmset = 1'b0;
    Minadv = 1'b0; Hrsadv = 1'b0; Alarmon = 1'b0; Snooze = 1'b0;
    TSec = 6'd59; TMin = 6'd59; THrs = 5'd0; AMin = 6'd0; AHrs = 5'd0;

    // Reset with Pulse active and carry conditions present.
    tick(); tick();
    check("reset_outputs", int'(all_out), 0);

    Reset = 1'b0;
    tick();
    check("first_pulse_carry", int'(all_out), 10'b1110000000);
    Pulse = 1'b0;
    tick();
    check("strobe_one_wide", int'(all_out), 0);

    TSec = 6'd59; TMin = 6'd10;
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("min_carry_only", int'({SecInc, MinInc, HrsInc}), 3'b110);
    TSec = 6'd5;
    tick();
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("sec_only", int'({SecInc, MinInc, HrsInc}), 3'b100);
    tick();

    // Time set: seconds held at 59 and minutes at 59 to expose any carry.
    TSec = 6'd59; TMin = 6'd59;
    Timeset = 1'b1;
    tick();
    check("tset_mode", int'(Mode), 1);
    check("tset_secclr_entry", int'(SecClr), 1);
    clr_counts();
    Minadv = 1'b1;
    for (int i = 0; i < 50; i++) pulse_count();
    Minadv = 1'b0; Hrsadv = 1'b1;
    for (int i = 0; i < 7; i++) pulse_count();
    Hrsadv = 1'b0;
    check("tset_mininc_cnt", n_min, 50);
    check("tset_hrsinc_cnt", n_hrs, 7);
    check("tset_secinc_cnt", n_sec, 0);
    check("tset_secclr_cnt", n_clr, 0);
    check("tset_alarm_cnt", n_amin + n_ahrs, 0);

    // Alarm set: time keeps running, alarm registers advance.
    TSec = 6'd10;
    Timeset = 1'b0; Alarmset = 1'b1;
    tick();
    check("aset_mode", int'(Mode), 2);
    check("aset_dispsel", int'(DispSel), 1);
    clr_counts();
    Hrsadv = 1'b1;
    for (int i = 0; i < 8; i++) pulse_count();
    Hrsadv = 1'b0; Minadv = 1'b1;
    pulse_count();
    check("aset_ahrsinc_cnt", n_ahrs, 8);
    check("aset_amininc_cnt", n_amin, 1);
    check("aset_secinc_cnt", n_sec, 9);
    check("aset_mininc_cnt", n_min, 0);
    check("aset_secclr_cnt", n_clr, 0);

    // Leaving ASET on the same cycle as a Pulse: old mode qualifies it.
    Alarmset = 1'b0; Pulse = 1'b1;
    tick();
    Pulse = 1'b0; Minadv = 1'b0;
    check("modechg_amininc", int'(AMinInc), 1);
    check("modechg_mode_run", int'({Mode, DispSel}), 0);
    tick();
    check("run_no_amininc", int'(AMinInc), 0);

    // Alarm at 08:01, time 08:00:59 -> 08:01:00.
    AHrs = 5'd8; AMin = 6'd1; THrs = 5'd8; TMin = 6'd0; Alarmon = 1'b1;
    tick(); tick();
    TMin = 6'd1; TSec = 6'd0;
    tick();
    check("buzz_not_yet", int'(Buzz), 0);
    tick();
    check("buzz_two_clks", int'(Buzz), 1);
    for (int i = 0; i < 3; i++) pulse_gap();
    check("buzz_ring_3", int'(Buzz), 1);
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("buzz_ring_done", int'(Buzz), 0);
    tick(); tick(); tick();
    check("buzz_no_rering", int'(Buzz), 0);

    // Snooze then re-ring, then cancel with Alarmon.
    retrigger();
    check("buzz_retrig", int'(Buzz), 1);
    Snooze = 1'b1; tick(); Snooze = 1'b0;
    check("snooze_silent", int'(Buzz), 0);
    pulse_gap(); pulse_gap();
    check("snooze_2", int'(Buzz), 0);
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("snooze_rering", int'(Buzz), 1);
    Alarmon = 1'b0; tick();
    check("alarmoff_ring", int'(Buzz), 0);
    Alarmon = 1'b1;
    for (int i = 0; i < 4; i++) pulse_gap();
    check("alarmoff_idle", int'(Buzz), 0);

    // Alarmon=0 together with Snooze: must go IDLE, not SNOOZE.
    retrigger();
    check("buzz_retrig2", int'(Buzz), 1);
    Alarmon = 1'b0; Snooze = 1'b1; tick();
    Snooze = 1'b0; Alarmon = 1'b1;
    check("off_over_snooze", int'(Buzz), 0);
    for (int i = 0; i < 4; i++) pulse_gap();
    check("off_over_snooze_idle", int'(Buzz), 0);

    // Match arising during TSET never triggers.
    TMin = 6'd2; tick(); tick();
    Timeset = 1'b1; tick();
    TMin = 6'd1; tick(); tick(); tick();
    check("tset_match_nobuzz", int'(Buzz), 0);
    Timeset = 1'b0; tick(); tick(); tick();
    check("tset_exit_nobuzz", int'(Buzz), 0);

    // Timeset and Alarmset together: TSET wins.
    Timeset = 1'b1; Alarmset = 1'b1; Minadv = 1'b1; Hrsadv = 1'b1;
    tick();
    check("both_mode", int'({Mode, DispSel}), 3'b010);
    Pulse = 1'b1; tick(); Pulse = 1'b0;
    check("both_strobes", int'({SecInc, MinInc, HrsInc, AMinInc, AHrsInc}),
          5'b01100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
